// File: rtl/all_registers.sv
// all_registers: 32x64 register file with two combinational read ports and one synchronous write port
module all_registers #(
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32,
  parameter int SEL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [SEL_W-1:0]  sel_r1,
  input  logic [SEL_W-1:0]  sel_r2,
  input  logic [SEL_W-1:0]  sel_w,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (write)
      regs[sel_w] <= data_in;
  // no bypass: a same-cycle write shows up only after the edge
  assign data_out1 = regs[sel_r1];
  assign data_out2 = regs[sel_r2];
endmodule

// File: tb/tb_all_registers.sv
// tb_all_registers: vector table, corner sequences and randomized checks against an array model
module tb_all_registers;
  logic        clk = 0;
  logic        reset = 0, write = 0;
  logic [4:0]  sel_r1 = 0, sel_r2 = 0, sel_w = 0;
  logic [63:0] data_in = 0;
  logic [63:0] data_out1, data_out2;
  logic [63:0] model [32];
  int vectors = 0, miscompares = 0;

  all_registers dut (
    .clk(clk), .reset(reset), .write(write), .sel_r1(sel_r1), .sel_r2(sel_r2),
    .sel_w(sel_w), .data_in(data_in), .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, wr;
    logic [4:0]  sw, s1, s2;
    logic [63:0] d, e1, e2;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one rising edge with the current inputs; the model follows the same rules
  task automatic tick();
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) model[i] = '0;
    else if (write) model[sel_w] = data_in;
    #1;
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b, input string name);
    sel_r1 = a;
    sel_r2 = b;
    #1;
    check({name, "_p1"}, data_out1, model[a]);
    check({name, "_p2"}, data_out2, model[b]);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd31, 64'h0, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd31, 64'h1234567812345678, 64'h1234567812345678, 64'h0};
    tbl[2] = '{1'b0, 1'b1, 5'd31, 5'd0,  5'd31, 64'h00000000FFFFFFFF, 64'h1234567812345678, 64'h00000000FFFFFFFF};
    tbl[3] = '{1'b0, 1'b0, 5'd5,  5'd31, 5'd5,  64'h0000000000534642, 64'h00000000FFFFFFFF, 64'h0};
    tbl[4] = '{1'b0, 1'b1, 5'd7,  5'd7,  5'd0,  64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 64'h1234567812345678};
    tbl[5] = '{1'b1, 1'b1, 5'd3,  5'd3,  5'd31, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};

    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      sel_r1 = i[4:0];
      sel_r2 = 5'(31 - i);
      #1;
      check("reset_p1", data_out1, 64'h0);
      check("reset_p2", data_out2, 64'h0);
    end

    for (int k = 0; k < 6; k++) begin
      reset = tbl[k].rst;
      write = tbl[k].wr;
      sel_w = tbl[k].sw;
      data_in = tbl[k].d;
      tick();
      reset = 0;
      write = 0;
      sel_r1 = tbl[k].s1;
      sel_r2 = tbl[k].s2;
      #1;
      check("table_p1", data_out1, tbl[k].e1);
      check("table_p2", data_out2, tbl[k].e2);
    end
    sel_r1 = 0;
    #1;
    check("rst_prio_r0", data_out1, 64'h0);

    // collision: old value before the edge, new value right after
    write = 1;
    sel_w = 7;
    sel_r1 = 7;
    sel_r2 = 9;
    data_in = 64'hDEADBEEFCAFEF00D;
    #1;
    check("nobypass_pre", data_out1, 64'h0);
    tick();
    write = 0;
    #1;
    check("nobypass_post", data_out1, 64'hDEADBEEFCAFEF00D);
    check("nobypass_other", data_out2, 64'h0);

    for (int i = 0; i < 32; i++) begin
      write = 1;
      sel_w = i[4:0];
      data_in = 64'h1 << (i % 64);
      tick();
    end
    write = 0;
    for (int i = 0; i < 32; i++) begin
      sel_r1 = i[4:0];
      sel_r2 = i[4:0];
      #1;
      check("walk_same_p1", data_out1, 64'h1 << i);
      check("walk_same_p2", data_out2, 64'h1 << i);
      read2(i[4:0], 5'(31 - i), "walk_cross");
    end

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 29) == 0);
      write = $urandom_range(0, 1);
      sel_w = 5'($urandom);
      data_in = {$urandom, $urandom};
      sel_r1 = ($urandom_range(0, 3) == 0) ? sel_w : 5'($urandom);
      sel_r2 = 5'($urandom);
      #1;
      check("rand_pre_p1", data_out1, model[sel_r1]);
      check("rand_pre_p2", data_out2, model[sel_r2]);
      tick();
      check("rand_post_p1", data_out1, model[sel_r1]);
      check("rand_post_p2", data_out2, model[sel_r2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
